// File: rtl/modexp_pkg.sv
// Shared encodings for modexp: Gray-coded FSM states and the rem-call op tag.
// Defines the GRAY macro used to derive the state codes.
`ifndef GRAY
`define GRAY(x) ((x) ^ ((x) >> 1))
`endif

package modexp_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'(`GRAY(0)),
    ST_RBASE = 3'(`GRAY(1)),
    ST_SQR   = 3'(`GRAY(2)),
    ST_MUL   = 3'(`GRAY(3)),
    ST_WLO   = 3'(`GRAY(4)),
    ST_WHI   = 3'(`GRAY(5)),
    ST_DONE  = 3'(`GRAY(6))
  } state_t;

  typedef enum logic [1:0] {
    OP_BASE = 2'd0,
    OP_SQR  = 2'd1,
    OP_MUL  = 2'd2
  } op_t;

endpackage

// File: rtl/modexp.sv
// Square-and-multiply modular exponentiation; each reduction is a call to an external rem block.
// Optional: MODEXP_SKIP_LZ_EN skips squares for leading-zero exponent bits.
module modexp
  import modexp_pkg::*;
#(
  parameter int unsigned MSB = 7
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               enable,
  input  logic               req,
  output logic               ack,
  output logic [2:0]         cst,
  input  logic [MSB:0]       base,
  input  logic [MSB:0]       expo,
  input  logic [MSB:0]       modulus,
  output logic [MSB:0]       result,
  output logic               err,
  output logic               rem_req,
  input  logic               rem_ack,
  output logic [2*MSB+1:0]   rem_dividend,
  output logic [MSB:0]       rem_divisor,
  input  logic [MSB:0]       rem_quot_rem
);

  localparam int unsigned W  = MSB + 1;
  localparam int unsigned IW = (W > 1) ? $clog2(W) : 1;

  state_t         state_q, state_d;
  op_t            op_q;
  logic           req_d;
  logic           req_x;
  logic [MSB:0]   b_q, e_q, n_q, acc_q, bm_q;
  logic [IW-1:0]  i_q;
  logic           err_q;
  logic [2*W-1:0] mul_a, mul_b, prod;
  logic           n_illegal;
  logic           last_bit;
  logic           skip_sqr;

  assign req_x     = req ^ req_d;
  // rem sign-extends its divisor, so a set MSB cannot be reduced.
  assign n_illegal = (n_q == '0) || n_q[MSB];
  assign last_bit  = (i_q == '0);

`ifdef MODEXP_SKIP_LZ_EN
  // No one bit processed yet means acc is still its initial value; squaring it is a no-op.
  assign skip_sqr = ((e_q >> i_q) == '0);
`else
  assign skip_sqr = 1'b0;
`endif

  always_comb begin
    mul_a = {{W{1'b0}}, acc_q};
    mul_b = (state_q == ST_MUL) ? {{W{1'b0}}, bm_q} : {{W{1'b0}}, acc_q};
    prod  = mul_a * mul_b;
  end

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
    end else if (enable) begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE:  if (req_x) state_d = ST_RBASE;
      ST_RBASE: state_d = n_illegal ? ST_DONE : ST_WLO;
      ST_SQR: begin
        if (skip_sqr) state_d = last_bit ? ST_DONE : ST_SQR;
        else          state_d = ST_WLO;
      end
      ST_MUL:   state_d = ST_WLO;
      ST_WLO:   if (!rem_ack) state_d = ST_WHI;
      ST_WHI: begin
        if (rem_ack) begin
          unique case (op_q)
            OP_BASE: state_d = ST_SQR;
            OP_SQR:  state_d = e_q[i_q] ? ST_MUL : (last_bit ? ST_DONE : ST_SQR);
            default: state_d = last_bit ? ST_DONE : ST_SQR;
          endcase
        end
      end
      ST_DONE:  state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  // Outputs
  always_comb begin
    ack         = (state_q == ST_IDLE);
    cst         = state_q;
    rem_divisor = n_q;
  end

  // Datapath and rem handshake registers
  always_ff @(posedge clk) begin
    if (rst) begin
      req_d        <= 1'b0;
      b_q          <= '0;
      e_q          <= '0;
      n_q          <= '0;
      acc_q        <= '0;
      bm_q         <= '0;
      i_q          <= '0;
      op_q         <= OP_BASE;
      err_q        <= 1'b0;
      result       <= '0;
      err          <= 1'b0;
      rem_req      <= 1'b0;
      rem_dividend <= '0;
    end else if (enable) begin
      req_d <= req;
      unique case (state_q)
        ST_IDLE: begin
          if (req_x) begin
            b_q   <= base;
            e_q   <= expo;
            n_q   <= modulus;
            acc_q <= W'(1);
            i_q   <= IW'(MSB);
          end
        end
        ST_RBASE: begin
          if (n_illegal) begin
            acc_q <= '0;
            err_q <= 1'b1;
          end else begin
            err_q        <= 1'b0;
            rem_dividend <= {{W{1'b0}}, b_q};
            rem_req      <= ~rem_req;
            op_q         <= OP_BASE;
          end
        end
        ST_SQR: begin
          if (skip_sqr) begin
            if (!last_bit) i_q <= i_q - 1'b1;
          end else begin
            rem_dividend <= prod;
            rem_req      <= ~rem_req;
            op_q         <= OP_SQR;
          end
        end
        ST_MUL: begin
          rem_dividend <= prod;
          rem_req      <= ~rem_req;
          op_q         <= OP_MUL;
        end
        ST_WHI: begin
          if (rem_ack) begin
            if (op_q == OP_BASE) begin
              bm_q  <= rem_quot_rem;
              acc_q <= (n_q == W'(1)) ? '0 : W'(1);
            end else begin
              acc_q <= rem_quot_rem;
              if (!((op_q == OP_SQR) && e_q[i_q]) && !last_bit) i_q <= i_q - 1'b1;
            end
          end
        end
        ST_DONE: begin
          result <= acc_q;
          err    <= err_q;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_modexp.sv
// Self-checking bench for modexp with a behavioural toggle-req/level-ack rem responder.
module tb_modexp;

  localparam int MSB = 7;
  localparam int W   = MSB + 1;

  typedef struct packed {
    logic [W-1:0] res;
    logic         err;
  } exp_t;

  logic           clk = 1'b0;
  logic           rst = 1'b1;
  logic           enable = 1'b1;
  logic           req = 1'b0;
  logic           ack;
  logic [2:0]     cst;
  logic [W-1:0]   base = '0, expo = '0, modulus = '0;
  logic [W-1:0]   result;
  logic           err;
  logic           rem_req;
  logic           rem_ack;
  logic [2*W-1:0] rem_dividend;
  logic [W-1:0]   rem_divisor;
  logic [W-1:0]   rem_quot_rem;

  int   n_checks = 0;
  int   n_fail   = 0;
  int   rem_calls = 0;
  exp_t sb[$];

  always #5 clk = ~clk;

  modexp #(.MSB(MSB)) dut (
    .clk          (clk),
    .rst          (rst),
    .enable       (enable),
    .req          (req),
    .ack          (ack),
    .cst          (cst),
    .base         (base),
    .expo         (expo),
    .modulus      (modulus),
    .result       (result),
    .err          (err),
    .rem_req      (rem_req),
    .rem_ack      (rem_ack),
    .rem_dividend (rem_dividend),
    .rem_divisor  (rem_divisor),
    .rem_quot_rem (rem_quot_rem)
  );

  // rem responder: drops ack one edge after a toggle, answers a few cycles later
  logic           rq_d;
  logic [2*W-1:0] r_div;
  int             r_cnt;
  always @(posedge clk) begin
    if (rst) begin
      rq_d         <= 1'b0;
      rem_ack      <= 1'b1;
      r_cnt        <= 0;
      r_div        <= '0;
      rem_quot_rem <= '0;
    end else if (enable) begin
      rq_d <= rem_req;
      if (rem_ack && (rem_req != rq_d)) begin
        rem_ack   <= 1'b0;
        r_div     <= rem_dividend;
        r_cnt     <= 3;
        rem_calls <= rem_calls + 1;
      end else if (!rem_ack) begin
        if (r_cnt == 0) begin
          rem_ack      <= 1'b1;
          rem_quot_rem <= (rem_divisor == '0) ? '0 : W'(r_div % {{W{1'b0}}, rem_divisor});
        end else begin
          r_cnt <= r_cnt - 1;
        end
      end
    end
  end

  function automatic logic [W-1:0] ref_modexp(input int b, input int e, input int n);
    int r;
    r = 1 % n;
    for (int k = 0; k < e; k++) r = (r * (b % n)) % n;
    return W'(r);
  endfunction

  task automatic start_op(input int b, input int e, input int n, input int res, input bit er);
    exp_t ex;
    @(negedge clk);
    base    = W'(b);
    expo    = W'(e);
    modulus = W'(n);
    req     = ~req;
    ex.res  = W'(res);
    ex.err  = er;
    sb.push_back(ex);
  endtask

  task automatic finish_op(input string name, input bit chk_fall, output int low);
    exp_t ex;
    low = 0;
    if (chk_fall) begin
      @(negedge clk);
      n_checks++;
      if (ack !== 1'b0) begin
        n_fail++;
        $display("FAIL %s ack_fall: ack=%b required 0", name, ack);
      end
    end
    while (ack === 1'b0 && low < 3000) begin
      low++;
      @(negedge clk);
    end
    n_checks++;
    if (ack !== 1'b1) begin
      n_fail++;
      $display("FAIL %s timeout: ack=%b required 1", name, ack);
    end
    n_checks++;
    if (sb.size() == 0) begin
      n_fail++;
      $display("FAIL %s scoreboard: empty, required an entry", name);
    end else begin
      ex = sb.pop_front();
      n_checks++;
      if (result !== ex.res || err !== ex.err) begin
        n_fail++;
        $display("FAIL %s result: got %0d err=%b, required %0d err=%b",
                 name, result, err, ex.res, ex.err);
      end
    end
  endtask

  task automatic check_reset_values(input string name);
    n_checks++;
    if (ack !== 1'b1 || cst !== 3'b000 || result !== '0 || err !== 1'b0 ||
        rem_req !== 1'b0 || rem_dividend !== '0) begin
      n_fail++;
      $display("FAIL %s: ack=%b cst=%b result=%0d err=%b rem_req=%b div=%0d, required 1 000 0 0 0 0",
               name, ack, cst, result, err, rem_req, rem_dividend);
    end
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clk);
    check_reset_values("reset_held");
    rst = 1'b0;
    @(negedge clk);
    check_reset_values("reset_released");
  endtask

  task automatic test_basic();
    int low;
    start_op(4, 13, 97, 93, 1'b0);
    finish_op("basic_4_13_97", 1'b1, low);
  endtask

  task automatic test_rsa();
    int low;
    start_op(7, 3, 33, 13, 1'b0);
    finish_op("rsa_encrypt", 1'b1, low);
    start_op(13, 7, 33, 7, 1'b0);
    finish_op("rsa_decrypt", 1'b1, low);
  endtask

  task automatic test_expo_zero();
    int low;
    start_op(5, 0, 10, 1, 1'b0);
    finish_op("expo0_mod10", 1'b1, low);
    start_op(5, 0, 1, 0, 1'b0);
    finish_op("expo0_mod1", 1'b1, low);
  endtask

  task automatic test_base_reduce();
    int low;
    start_op(200, 2, 7, 2, 1'b0);
    finish_op("base_reduce", 1'b1, low);
  endtask

  task automatic test_illegal();
    int low;
    int calls0;
    int mods[2] = '{0, 128};
    foreach (mods[k]) begin
      calls0 = rem_calls;
      start_op(9, 5, mods[k], 0, 1'b1);
      finish_op("illegal_mod", 1'b1, low);
      n_checks++;
      if (low != 2) begin
        n_fail++;
        $display("FAIL illegal_ack_low: %0d cycles, required 2", low);
      end
      n_checks++;
      if (rem_calls != calls0) begin
        n_fail++;
        $display("FAIL illegal_no_rem: %0d calls, required 0", rem_calls - calls0);
      end
    end
    start_op(3, 4, 11, 4, 1'b0);
    finish_op("err_clears", 1'b1, low);
  endtask

  task automatic test_drop_toggle();
    int low;
    int lows = 0;
    start_op(4, 13, 97, 93, 1'b0);
    repeat (6) @(negedge clk);
    base = 8'd5;
    req  = ~req;
    finish_op("drop_toggle", 1'b0, low);
    repeat (8) begin
      @(negedge clk);
      if (ack !== 1'b1) lows++;
    end
    n_checks++;
    if (lows != 0) begin
      n_fail++;
      $display("FAIL drop_toggle_restart: ack low %0d cycles after completion, required 0", lows);
    end
  endtask

  task automatic test_rst_mid();
    int low;
    start_op(4, 13, 97, 93, 1'b0);
    repeat (10) @(negedge clk);
    rst = 1'b1;
    req = 1'b0;
    @(negedge clk);
    check_reset_values("rst_mid");
    rst = 1'b0;
    sb.delete();
    start_op(6, 5, 13, 2, 1'b0);
    finish_op("after_rst", 1'b1, low);
  endtask

  task automatic test_enable_stall();
    int         low;
    int         guard = 0;
    int         moved = 0;
    logic [2:0] cst0;
    start_op(4, 13, 97, 93, 1'b0);
    while (rem_ack !== 1'b0 && guard < 200) begin
      @(negedge clk);
      guard++;
    end
    n_checks++;
    if (rem_ack !== 1'b0) begin
      n_fail++;
      $display("FAIL stall_wait: rem_ack=%b required 0", rem_ack);
    end
    enable = 1'b0;
    cst0   = cst;
    repeat (5) begin
      @(negedge clk);
      if (cst !== cst0) moved++;
    end
    n_checks++;
    if (moved != 0) begin
      n_fail++;
      $display("FAIL stall_hold: cst changed %0d times, required 0", moved);
    end
    enable = 1'b1;
    finish_op("enable_stall", 1'b0, low);
  endtask

  task automatic test_random();
    int low;
    int b, e, n;
    for (int k = 0; k < 4; k++) begin
      b = $urandom_range(0, 255);
      e = $urandom_range(0, 255);
      n = $urandom_range(1, 127);
      start_op(b, e, n, int'(ref_modexp(b, e, n)), 1'b0);
      finish_op("random", 1'b1, low);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_rsa();
    test_expo_zero();
    test_base_reduce();
    test_illegal();
    test_drop_toggle();
    test_rst_mid();
    test_enable_stall();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
